// File: rtl/acc_cmd_pkg.sv
// Shared definitions for the accelerator command endpoint.
// Holds the command codes, the header word field positions and the
// endpoint state encoding used by acc_cmd_endpoint.
package acc_cmd_pkg;

  // Command codes carried in the low byte of the header word
  localparam logic [7:0] CMD_EXEC_TASK = 8'h01;
  localparam logic [7:0] CMD_FINISHED  = 8'h03;

  // Command stream word width
  localparam int unsigned CMD_W = 64;

  // Header word field bit ranges
  localparam int unsigned HDR_CODE_LSB  = 0;
  localparam int unsigned HDR_CODE_MSB  = 7;
  localparam int unsigned HDR_NARGS_LSB = 8;
  localparam int unsigned HDR_NARGS_MSB = 15;

  // Endpoint control states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RD_TID    = 4'd1,
    ST_RD_PTID   = 4'd2,
    ST_RD_ARGS   = 4'd3,
    ST_DRAIN     = 4'd4,
    ST_START     = 4'd5,
    ST_EXEC      = 4'd6,
    ST_SEND_HDR  = 4'd7,
    ST_SEND_TID  = 4'd8,
    ST_SEND_PTID = 4'd9
  } state_t;

endpackage

// File: rtl/acc_cmd_argbuf.sv
// Task argument buffer: DEPTH x 64-bit storage with one write port and a
// registered read port. Storage is not reset; only the read register is.
// Reads of an index at or beyond DEPTH return zero.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset (read register only)
//   we     write enable
//   waddr  write index (caller guarantees waddr < DEPTH when we=1)
//   wdata  write data
//   raddr  read index
//   rdata  read data, one cycle after raddr
module acc_cmd_argbuf
  import acc_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [CMD_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [CMD_W-1:0] rdata
);

  logic [CMD_W-1:0] mem [DEPTH];

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port with out-of-range guard
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (32'(raddr) < DEPTH) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/acc_cmd_endpoint.sv
// Accelerator-side endpoint of the manager command interface.
// Accepts execute-task commands on the cmdin stream, buffers the task
// arguments, pulses acc_start, waits for acc_done and then returns a
// three-word finished-task message on the cmdout stream.
//
// Optional build macro: ACC_CMD_PROFILE_EN enables the exec_cycles and
// tasks_done profile counters; without it both outputs are tied to zero.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   cmdin_*              command stream in (tdest ignored)
//   cmdout_*             finished-task stream out (tid = ACC_ID)
//   acc_start            one-cycle kernel start pulse
//   acc_num_args         stored argument count, min(num_args, MAX_ARGS)
//   acc_arg_addr/data    argument read port, one-cycle registered read
//   acc_done             kernel finished pulse, honoured only in EXEC
//   err_*                sticky error flags
//   exec_cycles          cycles spent in EXEC for the last task
//   tasks_done           completed finished-task messages
module acc_cmd_endpoint
  import acc_cmd_pkg::*;
#(
  parameter int unsigned ACC_ID   = 0,
  parameter int unsigned MAX_ACCS = 16,
  parameter int unsigned MAX_ARGS = 15
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cmdin_tvalid,
  output logic                        cmdin_tready,
  input  logic [$clog2(MAX_ACCS)-1:0] cmdin_tdest,
  input  logic [63:0]                 cmdin_tdata,
  input  logic                        cmdin_tlast,
  output logic                        cmdout_tvalid,
  input  logic                        cmdout_tready,
  output logic [$clog2(MAX_ACCS)-1:0] cmdout_tid,
  output logic [63:0]                 cmdout_tdata,
  output logic                        acc_start,
  output logic [7:0]                  acc_num_args,
  input  logic [$clog2(MAX_ARGS)-1:0] acc_arg_addr,
  output logic [63:0]                 acc_arg_data,
  input  logic                        acc_done,
  output logic                        err_unknown_cmd,
  output logic                        err_arg_overflow,
  output logic                        err_short_cmd,
  output logic [31:0]                 exec_cycles,
  output logic [31:0]                 tasks_done
);

  localparam int unsigned IDW       = $clog2(MAX_ACCS);
  localparam int unsigned AW        = $clog2(MAX_ARGS);
  localparam int unsigned ARGS_CAP  = (MAX_ARGS > 255) ? 255 : MAX_ARGS;
  localparam logic [7:0]  ARGS_CAP8 = 8'(ARGS_CAP);

  state_t      state;
  logic [63:0] task_id;
  logic [63:0] ptask_id;
  logic [7:0]  nargs;
  logic [7:0]  arg_cnt;
  logic        drain_start;

  logic        in_xfer;
  logic [7:0]  hdr_code;
  logic [7:0]  hdr_nargs;
  logic [7:0]  nargs_clip;
  logic [8:0]  arg_next;
  logic        args_complete;
  logic        buf_we;

  // Routing happens upstream, so the destination field carries no information here
  logic        unused_tdest;
  assign unused_tdest = ^cmdin_tdest;

  assign in_xfer       = cmdin_tvalid & cmdin_tready;
  assign hdr_code      = cmdin_tdata[HDR_CODE_MSB:HDR_CODE_LSB];
  assign hdr_nargs     = cmdin_tdata[HDR_NARGS_MSB:HDR_NARGS_LSB];
  assign nargs_clip    = (nargs > ARGS_CAP8) ? ARGS_CAP8 : nargs;
  assign arg_next      = {1'b0, arg_cnt} + 9'd1;
  assign args_complete = arg_next >= {1'b0, nargs};
  assign buf_we        = (state == ST_RD_ARGS) && in_xfer && (arg_cnt < ARGS_CAP8);
  assign cmdout_tid    = IDW'(ACC_ID);

  // Argument storage, written in arrival order while reading arguments
  acc_cmd_argbuf #(
    .DEPTH (MAX_ARGS),
    .AW    (AW)
  ) u_argbuf (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (buf_we),
    .waddr (arg_cnt[AW-1:0]),
    .wdata (cmdin_tdata),
    .raddr (acc_arg_addr),
    .rdata (acc_arg_data)
  );

  // Command receive / kernel control / finish send state machine.
  // cmdin_tready is a flop updated on every transition between the
  // accepting and non-accepting state groups; it is low while in reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state            <= ST_IDLE;
      cmdin_tready     <= 1'b0;
      task_id          <= '0;
      ptask_id         <= '0;
      nargs            <= '0;
      arg_cnt          <= '0;
      drain_start      <= 1'b0;
      acc_start        <= 1'b0;
      acc_num_args     <= '0;
      cmdout_tvalid    <= 1'b0;
      cmdout_tdata     <= '0;
      err_unknown_cmd  <= 1'b0;
      err_arg_overflow <= 1'b0;
      err_short_cmd    <= 1'b0;
    end else begin
      acc_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cmdin_tready <= 1'b1;
          if (in_xfer) begin
            nargs <= hdr_nargs;
            if (hdr_code != CMD_EXEC_TASK) begin
              err_unknown_cmd <= 1'b1;
              drain_start     <= 1'b0;
              if (!cmdin_tlast) begin
                state <= ST_DRAIN;
              end
            end else if (cmdin_tlast) begin
              err_short_cmd <= 1'b1;
            end else begin
              state <= ST_RD_TID;
            end
          end
        end

        ST_RD_TID: begin
          if (in_xfer) begin
            task_id <= cmdin_tdata;
            if (cmdin_tlast) begin
              err_short_cmd <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              state <= ST_RD_PTID;
            end
          end
        end

        ST_RD_PTID: begin
          if (in_xfer) begin
            ptask_id <= cmdin_tdata;
            arg_cnt  <= '0;
            if (nargs == 8'd0) begin
              if (cmdin_tlast) begin
                state        <= ST_START;
                cmdin_tready <= 1'b0;
                acc_start    <= 1'b1;
                acc_num_args <= nargs_clip;
              end else begin
                // Surplus words on an argument-less task are tolerated
                drain_start <= 1'b1;
                state       <= ST_DRAIN;
              end
            end else if (cmdin_tlast) begin
              err_short_cmd <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              state <= ST_RD_ARGS;
            end
          end
        end

        ST_RD_ARGS: begin
          if (in_xfer) begin
            if (arg_cnt >= ARGS_CAP8) begin
              err_arg_overflow <= 1'b1;
            end
            if (arg_cnt != 8'hFF) begin
              arg_cnt <= arg_cnt + 8'd1;
            end
            if (cmdin_tlast) begin
              if (args_complete) begin
                state        <= ST_START;
                cmdin_tready <= 1'b0;
                acc_start    <= 1'b1;
                acc_num_args <= nargs_clip;
              end else begin
                err_short_cmd <= 1'b1;
                state         <= ST_IDLE;
              end
            end
          end
        end

        ST_DRAIN: begin
          if (in_xfer && cmdin_tlast) begin
            drain_start <= 1'b0;
            if (drain_start) begin
              state        <= ST_START;
              cmdin_tready <= 1'b0;
              acc_start    <= 1'b1;
              acc_num_args <= nargs_clip;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_START: begin
          state <= ST_EXEC;
        end

        ST_EXEC: begin
          if (acc_done) begin
            state         <= ST_SEND_HDR;
            cmdout_tvalid <= 1'b1;
            cmdout_tdata  <= {56'd0, CMD_FINISHED};
          end
        end

        ST_SEND_HDR: begin
          if (cmdout_tready) begin
            state        <= ST_SEND_TID;
            cmdout_tdata <= task_id;
          end
        end

        ST_SEND_TID: begin
          if (cmdout_tready) begin
            state        <= ST_SEND_PTID;
            cmdout_tdata <= ptask_id;
          end
        end

        ST_SEND_PTID: begin
          if (cmdout_tready) begin
            state         <= ST_IDLE;
            cmdin_tready  <= 1'b1;
            cmdout_tvalid <= 1'b0;
            cmdout_tdata  <= '0;
          end
        end

        default: begin
          state         <= ST_IDLE;
          cmdin_tready  <= 1'b0;
          cmdout_tvalid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACC_CMD_PROFILE_EN
  logic [31:0] exec_cnt;
  logic [31:0] task_cnt;

  // Kernel run time (saturating) and completed-task count (wrapping)
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      exec_cnt <= '0;
      task_cnt <= '0;
    end else begin
      if (state == ST_START) begin
        exec_cnt <= '0;
      end else if ((state == ST_EXEC) && (exec_cnt != 32'hFFFF_FFFF)) begin
        exec_cnt <= exec_cnt + 32'd1;
      end
      if ((state == ST_SEND_PTID) && cmdout_tready) begin
        task_cnt <= task_cnt + 32'd1;
      end
    end
  end

  assign exec_cycles = exec_cnt;
  assign tasks_done  = task_cnt;
`else
  assign exec_cycles = '0;
  assign tasks_done  = '0;
`endif

endmodule

// File: doc/acc_cmd_endpoint.md
Name: acc_cmd_endpoint

Overview:
- Accelerator-side endpoint of the manager command interface, one instance per accelerator.
- Receives execute-task commands from the manager's cmdin_out AXI-Stream and buffers the task arguments.
- Starts the accelerator kernel, waits for it to finish, then sends a finished-task message back on the manager's cmdout_in stream.

Parameters:
ACC_ID, 0, accelerator index; driven on cmdout_tid.
MAX_ACCS, 16, number of accelerators; ID width = $clog2(MAX_ACCS).
MAX_ARGS, 15, argument buffer depth (64-bit words).

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
cmdin_tvalid  in  1  command stream valid
cmdin_tready  out  1  command stream ready
cmdin_tdest  in  $clog2(MAX_ACCS)  destination; ignored (routing done upstream)
cmdin_tdata  in  64  command word
cmdin_tlast  in  1  last command word
cmdout_tvalid  out  1  finish stream valid
cmdout_tready  in  1  finish stream ready
cmdout_tid  out  $clog2(MAX_ACCS)  constant ACC_ID
cmdout_tdata  out  64  finish word
acc_start  out  1  one-cycle kernel start pulse
acc_num_args  out  8  stored argument count
acc_arg_addr  in  $clog2(MAX_ARGS)  argument read index
acc_arg_data  out  64  argument at acc_arg_addr, 1-cycle registered read
acc_done  in  1  kernel finished; pulse, sampled only in EXEC
err_unknown_cmd  out  1  sticky error flag
err_arg_overflow  out  1  sticky error flag
err_short_cmd  out  1  sticky error flag
exec_cycles  out  32  profile counter
tasks_done  out  32  profile counter

Behaviour:
- Reset (aresetn=0 at posedge): state IDLE; all outputs 0 except cmdout_tid=ACC_ID; sticky flags cleared; argument buffer contents unchanged.
- Command format:
  - Word0: [7:0]=code (0x01 execute), [15:8]=num_args.
  - Word1: task_id.
  - Word2: parent_task_id.
  - Words 3..: arguments; tlast on the final word.
- Transfer rule: a beat transfers only when tvalid&&tready.
- cmdin_tready=1 only in IDLE, RD_TID, RD_PTID, RD_ARGS, DRAIN.
- FSM:
  - IDLE: on a header beat, latch code and num_args.
    - code!=0x01: set err_unknown_cmd; go to DRAIN, or stay in IDLE if tlast.
    - code=0x01 with tlast: set err_short_cmd; stay in IDLE.
    - Otherwise go to RD_TID.
  - RD_TID: latch task_id. tlast here: err_short_cmd, back to IDLE. Otherwise go to RD_PTID.
  - RD_PTID: latch parent_task_id.
    - num_args=0: tlast expected; go to START. A missing tlast is tolerated: the remaining words are drained and the flow then goes to START.
    - num_args>0: tlast here gives err_short_cmd and back to IDLE; otherwise go to RD_ARGS.
  - RD_ARGS: write beat k to buf[k] when k<MAX_ARGS. Beats with k>=MAX_ARGS are discarded and set err_arg_overflow. Leave on tlast.
    - tlast before num_args beats: err_short_cmd, IDLE, no start.
    - tlast with k+1>=num_args: go to START.
  - DRAIN: accept beats until tlast, then IDLE.
  - START: acc_start=1 for exactly one cycle; acc_num_args=min(num_args,MAX_ARGS); go to EXEC.
  - EXEC: wait for acc_done, then go to SEND_HDR. acc_done outside EXEC is ignored.
  - SEND_HDR: tdata={56'b0,8'h03}. SEND_TID: tdata=task_id. SEND_PTID: tdata=parent_task_id.
  - Each SEND state holds tvalid and tdata stable until tready; after the SEND_PTID handshake go to IDLE.
- Latency:
  - Last arg beat to acc_start: 1 cycle.
  - acc_done to cmdout_tvalid: 1 cycle.
- Argument read port valid from acc_start until the next command header is accepted.
- Reset mid-operation (including mid-send) returns to IDLE; the partial output message is abandoned, and the system-level reset covers the manager side.

Optional Feature:
ACC_CMD_PROFILE_EN:
- Defined: exec_cycles clears at START and increments each EXEC cycle, saturating at 0xFFFFFFFF; it holds its value after EXEC. tasks_done increments (wrapping) on each SEND_PTID handshake.
- Undefined: both outputs are tied to 0 and no counter logic is generated.

Decomposition:
- Package acc_cmd_pkg:
  - Command codes CMD_EXEC_TASK=8'h01, CMD_FINISHED=8'h03.
  - Header field bit ranges.
  - State enum.
- One sub-module acc_cmd_argbuf: MAX_ARGS x 64 single-write, registered-read buffer.

Test Plan:
- Exec with num_args=2, words {0x0201, 0xAA, 0xBB, 0x11, 0x22(tlast)}, then acc_done 5 cycles after acc_start → acc_num_args=2, arg[1]=0x22, cmdout = 0x03, 0xAA, 0xBB with tid=ACC_ID; profile build: exec_cycles=5, tasks_done=1.
- Same flow with cmdout_tready held low 10 cycles, then random toggling → words unchanged and emitted exactly once, in order.
- Header 0x0105 (code 5), then 3 beats with tlast on the 3rd → err_unknown_cmd=1; no acc_start; cmdin_tready stays high; the next valid command completes normally.
- num_args=17, MAX_ARGS=15 → 15 args stored, err_arg_overflow=1, acc_num_args=15, task completes.
- Exec header with num_args=3 and tlast on the first arg → err_short_cmd=1, no acc_start, IDLE.
- aresetn low during EXEC and during SEND_TID → all outputs back to reset values; the next command runs cleanly.
